// File: rtl/imm_pkg.sv
// Shared types and constants for the LEGv8 immediate-generation stage:
// format tags, opcode match values and the bit positions of every field.
package imm_pkg;

  // Immediate format tag carried alongside the extended value
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_D    = 3'd2,
    IMM_B    = 3'd3,
    IMM_CB   = 3'd4,
    IMM_IW   = 3'd5
  } imm_kind_t;

  // I-type opcodes, instr[31:22]
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
  localparam logic [9:0]  OP_ANDI  = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI  = 10'b1011001000;
  localparam logic [9:0]  OP_EORI  = 10'b1101001000;
  // D-type opcodes, instr[31:21]
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  // B-type opcodes, instr[31:26]
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [5:0]  OP_BL    = 6'b100101;
  // CB-type opcodes, instr[31:24]
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  // IW-type opcodes, instr[31:23]
  localparam logic [8:0]  OP_MOVZ  = 9'b110100101;
  localparam logic [8:0]  OP_MOVK  = 9'b111100101;

  // Opcode field widths (all opcodes are left-aligned at bit 31)
  localparam int unsigned I_OP_W   = 10;
  localparam int unsigned D_OP_W   = 11;
  localparam int unsigned B_OP_W   = 6;
  localparam int unsigned CB_OP_W  = 8;
  localparam int unsigned IW_OP_W  = 9;

  // Immediate field positions
  localparam int unsigned I_IMM_LSB  = 10;
  localparam int unsigned I_IMM_W    = 12;
  localparam int unsigned D_IMM_LSB  = 12;
  localparam int unsigned D_IMM_W    = 9;
  localparam int unsigned B_IMM_LSB  = 0;
  localparam int unsigned B_IMM_W    = 26;
  localparam int unsigned CB_IMM_LSB = 5;
  localparam int unsigned CB_IMM_W   = 19;
  localparam int unsigned IW_IMM_LSB = 5;
  localparam int unsigned IW_IMM_W   = 16;
  localparam int unsigned IW_HW_LSB  = 21;
  localparam int unsigned IW_HW_W    = 2;

  // True when a 10-bit opcode field names one of the I-type ALU immediates
  function automatic logic is_i_op(input logic [9:0] op);
    logic hit;
    case (op)
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI, OP_EORI: hit = 1'b1;
      default:                                     hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/imm_gen_stage_if.sv
// Ready/valid bundle between IF/ID, the immediate stage and EX.
// slave: the stage's view; master: the surrounding pipeline's view.
interface imm_gen_stage_if #(
  parameter int DATA_W  = 64,
  parameter int INSTR_W = 32
);
  import imm_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  imm_out;
  imm_kind_t          imm_kind;

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, imm_out, imm_kind
  );

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, imm_out, imm_kind
  );

endinterface

// File: rtl/imm_decode.sv
// Combinational LEGv8 immediate decoder: classifies the instruction word,
// extracts the immediate field and extends it to DATA_W bits.
module imm_decode
  import imm_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic [INSTR_W-1:0] instr_i,
  output logic [DATA_W-1:0]  imm_o,
  output imm_kind_t          kind_o
);

  logic [I_OP_W-1:0]   op_i_s;
  logic [D_OP_W-1:0]   op_d_s;
  logic [B_OP_W-1:0]   op_b_s;
  logic [CB_OP_W-1:0]  op_cb_s;
  logic [IW_OP_W-1:0]  op_iw_s;
  logic [I_IMM_W-1:0]  imm12_s;
  logic [D_IMM_W-1:0]  imm9_s;
  logic [B_IMM_W-1:0]  imm26_s;
  logic [CB_IMM_W-1:0] imm19_s;
  logic [IW_IMM_W-1:0] imm16_s;
  logic [IW_HW_W-1:0]  hw_s;

  assign op_i_s  = instr_i[INSTR_W-1 -: I_OP_W];
  assign op_d_s  = instr_i[INSTR_W-1 -: D_OP_W];
  assign op_b_s  = instr_i[INSTR_W-1 -: B_OP_W];
  assign op_cb_s = instr_i[INSTR_W-1 -: CB_OP_W];
  assign op_iw_s = instr_i[INSTR_W-1 -: IW_OP_W];

  assign imm12_s = instr_i[I_IMM_LSB  +: I_IMM_W];
  assign imm9_s  = instr_i[D_IMM_LSB  +: D_IMM_W];
  assign imm26_s = instr_i[B_IMM_LSB  +: B_IMM_W];
  assign imm19_s = instr_i[CB_IMM_LSB +: CB_IMM_W];
  assign imm16_s = instr_i[IW_IMM_LSB +: IW_IMM_W];
  assign hw_s    = instr_i[IW_HW_LSB  +: IW_HW_W];

  // Select the format and build the extended immediate; branch offsets are
  // word offsets, so they gain two zero LSBs after sign extension
  always_comb begin
    imm_o  = {DATA_W{1'b0}};
    kind_o = IMM_NONE;
    if (is_i_op(op_i_s)) begin
      imm_o  = {{(DATA_W-I_IMM_W){1'b0}}, imm12_s};
      kind_o = IMM_I;
    end else if ((op_d_s == OP_LDUR) || (op_d_s == OP_STUR)) begin
      imm_o  = {{(DATA_W-D_IMM_W){imm9_s[D_IMM_W-1]}}, imm9_s};
      kind_o = IMM_D;
    end else if ((op_b_s == OP_B) || (op_b_s == OP_BL)) begin
      imm_o  = {{(DATA_W-B_IMM_W-2){imm26_s[B_IMM_W-1]}}, imm26_s, 2'b00};
      kind_o = IMM_B;
    end else if ((op_cb_s == OP_CBZ) || (op_cb_s == OP_CBNZ) ||
                 (op_cb_s == OP_BCOND)) begin
      imm_o  = {{(DATA_W-CB_IMM_W-2){imm19_s[CB_IMM_W-1]}}, imm19_s, 2'b00};
      kind_o = IMM_CB;
    end else if ((op_iw_s == OP_MOVZ) || (op_iw_s == OP_MOVK)) begin
      imm_o  = {{(DATA_W-IW_IMM_W){1'b0}}, imm16_s} << {hw_s, 4'b0000};
      kind_o = IMM_IW;
    end else begin
      imm_o  = {DATA_W{1'b0}};
      kind_o = IMM_NONE;
    end
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage. Decoded immediates are held in a
// two-entry skid buffer (main drives the outputs, skid absorbs one beat of
// back-pressure) so in_ready is a flop and never depends on out_ready.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int INSTR_W = 32
) (
  input logic             clk,
  input logic             reset,
  input logic             flush,
  imm_gen_stage_if.slave  bus
);

  logic [DATA_W-1:0] dec_imm_s;
  imm_kind_t         dec_kind_s;

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_imm_q,   main_imm_d;
  imm_kind_t         main_kind_q,  main_kind_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_imm_q,   skid_imm_d;
  imm_kind_t         skid_kind_q,  skid_kind_d;
  logic              in_ready_q,   in_ready_d;

  logic              accept_s;
  logic              deliver_s;

  imm_decode #(
    .DATA_W  (DATA_W),
    .INSTR_W (INSTR_W)
  ) u_decode (
    .instr_i (bus.instr),
    .imm_o   (dec_imm_s),
    .kind_o  (dec_kind_s)
  );

  assign accept_s  = bus.in_valid && in_ready_q;
  assign deliver_s = main_valid_q && bus.out_ready;

  // Skid-buffer next state: flush wins, then deliver/refill, then capture
  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_kind_d  = main_kind_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_kind_d  = skid_kind_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (deliver_s) begin
      if (skid_valid_q) begin
        // in_ready is low while skid holds a beat, so no accept here
        main_valid_d = 1'b1;
        main_imm_d   = skid_imm_q;
        main_kind_d  = skid_kind_q;
        skid_valid_d = 1'b0;
      end else if (accept_s) begin
        main_valid_d = 1'b1;
        main_imm_d   = dec_imm_s;
        main_kind_d  = dec_kind_s;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept_s) begin
      if (main_valid_q) begin
        skid_valid_d = 1'b1;
        skid_imm_d   = dec_imm_s;
        skid_kind_d  = dec_kind_s;
      end else begin
        main_valid_d = 1'b1;
        main_imm_d   = dec_imm_s;
        main_kind_d  = dec_kind_s;
      end
    end else begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
    end
    in_ready_d = !skid_valid_d;
  end

  // State registers; reset empties both entries and clears the output data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= {DATA_W{1'b0}};
      main_kind_q  <= IMM_NONE;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= {DATA_W{1'b0}};
      skid_kind_q  <= IMM_NONE;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_kind_q  <= main_kind_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_kind_q  <= skid_kind_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_valid_q;
  assign bus.imm_out   = main_imm_q;
  assign bus.imm_kind  = main_kind_q;

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Registered immediate-generation stage between the IF/ID register and the EX operand mux.
- Takes a 32-bit LEGv8 instruction word, identifies its immediate format, extracts the field and sign- or zero-extends it to 64 bits.
- Delivers the result through a ready/valid interface with a 2-entry skid buffer, so that back-pressure from EX (load-use stall) never creates a combinational ready path back to IF/ID.

Parameters:
- DATA_W, 64: width of the extended immediate.
- INSTR_W, 32: instruction word width (fixed by the ISA; the parameter exists only for readability).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low (0 = reset); asserts immediately, deasserts synchronously to clk.
- flush  input  1  synchronous squash (branch taken / mispredict).
- in_valid  input  1  instr is valid.
- in_ready  output  1  stage can accept; registered.
- instr  input  INSTR_W  instruction word from IF/ID.
- out_valid  output  1  imm_out / imm_kind are valid.
- out_ready  input  1  EX consumes this cycle.
- imm_out  output  DATA_W  extended immediate.
- imm_kind  output  3  format tag (imm_kind_t).

Behaviour:
- Reset (reset=0):
  - out_valid=0, imm_out=0, imm_kind=IMM_NONE, both buffer entries invalid.
  - in_ready reads 1, but nothing is captured while reset is low.
- Format decode, combinational from instr:
  - I-type ADDI/SUBI/ANDI/ORRI/EORI (instr[31:22] matches): imm12=instr[21:10], zero-extended, kind IMM_I.
  - D-type LDUR/STUR (instr[31:21] = 11111000010 / 11111000000): imm9=instr[20:12], sign-extended, kind IMM_D.
  - B/BL (instr[31:26] = 000101 / 100101): imm26=instr[25:0], sign-extended then shifted left 2, kind IMM_B.
  - CBZ/CBNZ/B.cond (instr[31:24] = 10110100 / 10110101 / 01010100): imm19=instr[23:5], sign-extended then shifted left 2, kind IMM_CB.
  - MOVZ/MOVK (instr[31:23] = 110100101 / 111100101): imm16=instr[20:5] zero-extended, shifted left 16*instr[22:21], kind IMM_IW.
  - Anything else (R-type, unknown): imm 0, kind IMM_NONE. Still passed through as a valid beat.
- Handshake:
  - Accept when in_valid && in_ready.
  - Deliver when out_valid && out_ready.
  - Latency: 1 cycle from accept to out_valid.
  - Throughput: 1 per cycle while out_ready=1.
- Skid buffer, entries main (drives the outputs) and skid:
  - Accept with main empty, or main delivering this cycle: result goes to main.
  - Accept with main full and not delivering: result goes to skid.
  - Deliver with skid full: skid moves to main.
  - in_ready = !skid_valid, registered. It drops the cycle after skid fills and rises the cycle after skid drains.
  - Order is strictly FIFO. Outputs hold stable while out_valid && !out_ready.
- flush=1:
  - Both entries are invalidated at the next edge; a beat accepted in the same cycle is dropped.
  - flush has priority over accept and deliver.
  - imm_out/imm_kind data registers hold their values (don't-care when invalid).
- Asynchronous reset mid-stream discards all contents immediately. The first accept after deassertion behaves as from empty.
- No arithmetic overflow is possible: the shifted branch immediates fit in 28 and 21 bits before extension.

Decomposition:
- Package imm_pkg:
  - imm_kind_t enum: IMM_NONE, IMM_I, IMM_D, IMM_B, IMM_CB, IMM_IW.
  - Opcode match constants: OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI, OP_EORI, OP_LDUR, OP_STUR, OP_B, OP_BL, OP_CBZ, OP_CBNZ, OP_BCOND, OP_MOVZ, OP_MOVK.
  - Field position constants.
- Sub-module imm_decode (purely combinational: instr -> imm, kind).
- The top level holds the skid buffer and the handshake logic only.

Test Plan:
- ADDI X1,X2,#0xABC: instr=0x912AF041, out_ready=1 -> next cycle out_valid=1, imm_out=0x0000000000000ABC, kind IMM_I.
- LDUR X0,[X1,#-8]: instr=0xF85F8020 -> imm_out=0xFFFFFFFFFFFFFFF8, kind IMM_D.
- B with imm26 = -1 (instr=0x17FFFFFF) -> imm_out=0xFFFFFFFFFFFFFFFC, kind IMM_B.
- MOVZ X3,#0x1234,LSL#32: instr=0xD2C24683 -> imm_out=0x0000123400000000, kind IMM_IW.
- Back-pressure and skid:
  - Stimulus: out_ready=0; present A, B, C back-to-back.
  - A lands in main; B lands in skid; in_ready=0 the cycle after B; C is held.
  - Raise out_ready: outputs A, B, C on consecutive cycles; in_ready returns to 1.
- Flush and reset:
  - flush=1 with main and skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1, and no stale beat ever appears.
  - reset=0 asserted mid-transfer -> out_valid=0 without waiting for a clock edge.
